// File: rtl/countdown_timer.sv
// countdown_timer: hours/minutes/seconds countdown with load, start and pause.
//   CLK                  rising-edge clock
//   RST_N                asynchronous active-low reset
//   Tick                 one-second qualifier, consumed only while running
//   Load, Load_Hours/Mins/Secs   preset request and value (binary)
//   Start, Pause         run control
//   Hours, Mins, Secs    registered remaining time
//   Busy                 running or paused
//   Done                 one-cycle pulse when the count reaches 0:00:00
//   Expired              count has run out; only a valid Load leaves
//   Load_Err             one-cycle pulse on a rejected Load
module countdown_timer (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Tick,
  input  logic       Load,
  input  logic [5:0] Load_Hours,
  input  logic [5:0] Load_Mins,
  input  logic [5:0] Load_Secs,
  input  logic       Start,
  input  logic       Pause,
  output logic [5:0] Hours,
  output logic [5:0] Mins,
  output logic [5:0] Secs,
  output logic       Busy,
  output logic       Done,
  output logic       Expired,
  output logic       Load_Err
);

  localparam int unsigned FW = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [FW-1:0]   hours_n, mins_n, secs_n;
  logic            done_n, load_err_n;
  logic            load_ok;
  logic            count_nz;
  logic            last_sec;

  // A preset must be a legal time of day and cannot interrupt a running count.
  assign load_ok  = (Load_Hours <= FW'(23)) && (Load_Mins <= FW'(59)) &&
                    (Load_Secs <= FW'(59)) && (state != RUN);
  assign count_nz = (Hours != '0) || (Mins != '0) || (Secs != '0);
  // The decrement about to be applied lands on 0:00:00.
  assign last_sec = (Hours == '0) && (Mins == '0) && (Secs == FW'(1));

  // State and registered outputs; Busy/Expired track the registered state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      Hours    <= '0;
      Mins     <= '0;
      Secs     <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Expired  <= 1'b0;
      Load_Err <= 1'b0;
    end else begin
      state    <= state_n;
      Hours    <= hours_n;
      Mins     <= mins_n;
      Secs     <= secs_n;
      Busy     <= (state_n == RUN) || (state_n == PAUSED);
      Done     <= done_n;
      Expired  <= (state_n == EXPIRED);
      Load_Err <= load_err_n;
    end
  end

  // Next-state and next-count logic; Load outranks Start/Pause.
  always_comb begin
    state_n    = state;
    hours_n    = Hours;
    mins_n     = Mins;
    secs_n     = Secs;
    done_n     = 1'b0;
    load_err_n = 1'b0;

    if (Load) begin
      if (load_ok) begin
        hours_n = Load_Hours;
        mins_n  = Load_Mins;
        secs_n  = Load_Secs;
        state_n = IDLE;
      end else begin
        load_err_n = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (Start && count_nz) state_n = RUN;
        end
        PAUSED: begin
          if (Start && !Pause && count_nz) state_n = RUN;
        end
        RUN: begin
          if (Pause) begin
            state_n = PAUSED;
          end else if (Tick) begin
            if (Secs != '0) begin
              secs_n = Secs - FW'(1);
            end else if (Mins != '0) begin
              mins_n = Mins - FW'(1);
              secs_n = FW'(59);
            end else if (Hours != '0) begin
              hours_n = Hours - FW'(1);
              mins_n  = FW'(59);
              secs_n  = FW'(59);
            end
            if (last_sec) begin
              state_n = EXPIRED;
              done_n  = 1'b1;
            end
          end
        end
        EXPIRED: begin
          // Count already rests at zero; nothing but a valid Load matters.
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a table of one-cycle vectors with
// hand-derived expected outputs, fed through a scoreboard queue, plus a
// hand-written reset-during-run sequence.
module tb_countdown_timer;

  logic       CLK;
  logic       RST_N;
  logic       Tick, Load, Start, Pause;
  logic [5:0] Load_Hours, Load_Mins, Load_Secs;
  logic [5:0] Hours, Mins, Secs;
  logic       Busy, Done, Expired, Load_Err;

  countdown_timer dut (
    .CLK(CLK), .RST_N(RST_N), .Tick(Tick), .Load(Load),
    .Load_Hours(Load_Hours), .Load_Mins(Load_Mins), .Load_Secs(Load_Secs),
    .Start(Start), .Pause(Pause),
    .Hours(Hours), .Mins(Mins), .Secs(Secs),
    .Busy(Busy), .Done(Done), .Expired(Expired), .Load_Err(Load_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       tick, load, start, pause;
    logic [5:0] lh, lm, ls;
    logic [5:0] eh, em, es;
    logic       ebusy, edone, eexp, eerr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic t, input logic l, input logic [5:0] lh,
                              input logic [5:0] lm, input logic [5:0] ls,
                              input logic st, input logic p,
                              input logic [5:0] eh, input logic [5:0] em,
                              input logic [5:0] es, input logic eb,
                              input logic ed, input logic ee, input logic er);
    vec_t v;
    v.tick = t; v.load = l; v.lh = lh; v.lm = lm; v.ls = ls;
    v.start = st; v.pause = p;
    v.eh = eh; v.em = em; v.es = es;
    v.ebusy = eb; v.edone = ed; v.eexp = ee; v.eerr = er;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    check({tag, " Hours"},    int'(Hours),    int'(e.eh));
    check({tag, " Mins"},     int'(Mins),     int'(e.em));
    check({tag, " Secs"},     int'(Secs),     int'(e.es));
    check({tag, " Busy"},     int'(Busy),     int'(e.ebusy));
    check({tag, " Done"},     int'(Done),     int'(e.edone));
    check({tag, " Expired"},  int'(Expired),  int'(e.eexp));
    check({tag, " Load_Err"}, int'(Load_Err), int'(e.eerr));
  endtask

  // Drive one cycle of inputs at the falling edge, check just after the rising edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    @(negedge CLK);
    Tick = v.tick; Load = v.load; Start = v.start; Pause = v.pause;
    Load_Hours = v.lh; Load_Mins = v.lm; Load_Secs = v.ls;
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard: got 0 entries want 1", tag);
    end else begin
      e = exp_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    RST_N = 1'b0;
    Tick = 0; Load = 0; Start = 0; Pause = 0;
    Load_Hours = 0; Load_Mins = 0; Load_Secs = 0;
    #1;
    z = mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0);
    check_outputs("reset", z);
    #12;
    @(negedge CLK);
    RST_N = 1'b1;

    //          T L  lh lm ls St P   h  m  s  B D E Er
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,  0, 0, 0, 0,0,0,0)); // start at zero ignored
    tbl.push_back(mk(0,1,24, 0, 0,0,0,  0, 0, 0, 0,0,0,1)); // hours 24 rejected
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,  0, 0, 0, 0,0,0,0)); // err is one cycle
    tbl.push_back(mk(0,1, 0, 0, 3,0,0,  0, 0, 3, 0,0,0,0)); // load 0:00:03
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,  0, 0, 3, 1,0,0,0)); // start
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,  0, 0, 2, 1,0,0,0));
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,  0, 0, 1, 1,0,0,0));
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,  0, 0, 0, 0,1,1,0)); // done pulse, expired
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,  0, 0, 0, 0,0,1,0)); // done dropped
    tbl.push_back(mk(1,0, 0, 0, 0,1,1,  0, 0, 0, 0,0,1,0)); // expired ignores ctrl
    tbl.push_back(mk(0,1, 0,60, 0,0,0,  0, 0, 0, 0,0,1,1)); // mins 60 rejected
    tbl.push_back(mk(0,1, 0, 0, 2,0,0,  0, 0, 2, 0,0,0,0)); // load leaves expired
    tbl.push_back(mk(0,1, 1, 0, 0,0,0,  1, 0, 0, 0,0,0,0)); // load 1:00:00
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,  1, 0, 0, 1,0,0,0));
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,  0,59,59, 1,0,0,0)); // hour borrow
    tbl.push_back(mk(0,0, 0, 0, 0,0,1,  0,59,59, 1,0,0,0)); // pause
    tbl.push_back(mk(0,1, 0, 1, 0,0,0,  0, 1, 0, 0,0,0,0)); // load from paused
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,  0, 1, 0, 1,0,0,0));
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,  0, 0,59, 1,0,0,0)); // minute borrow
    tbl.push_back(mk(0,1, 0, 0, 5,0,0,  0, 0,59, 1,0,0,1)); // load in run rejected
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,  0, 0,58, 1,0,0,0)); // keeps counting
    tbl.push_back(mk(0,0, 0, 0, 0,0,0,  0, 0,58, 1,0,0,0)); // tick low holds
    tbl.push_back(mk(0,0, 0, 0, 0,0,1,  0, 0,58, 1,0,0,0)); // pause
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,  0, 0,58, 1,0,0,0)); // tick ignored paused
    tbl.push_back(mk(0,0, 0, 0, 0,1,1,  0, 0,58, 1,0,0,0)); // start+pause stays
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,  0, 0,58, 1,0,0,0)); // proves still paused
    tbl.push_back(mk(0,1, 0, 0,10,1,0,  0, 0,10, 0,0,0,0)); // load beats start
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,  0, 0,10, 1,0,0,0));
    tbl.push_back(mk(1,0, 0, 0, 0,1,1,  0, 0,10, 1,0,0,0)); // pause wins, no dec
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,  0, 0,10, 1,0,0,0)); // paused: no dec
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,  0, 0,10, 1,0,0,0)); // resume
    tbl.push_back(mk(1,0, 0, 0, 0,0,0,  0, 0, 9, 1,0,0,0));
    tbl.push_back(mk(0,0, 0, 0, 0,0,1,  0, 0, 9, 1,0,0,0));
    tbl.push_back(mk(0,1,23,59,59,0,0, 23,59,59, 0,0,0,0)); // max legal preset
    tbl.push_back(mk(0,1,23,59,60,0,0, 23,59,59, 0,0,0,1)); // secs 60 rejected
    tbl.push_back(mk(0,0, 0, 0, 0,1,0, 23,59,59, 1,0,0,0));
    tbl.push_back(mk(1,0, 0, 0, 0,0,0, 23,59,58, 1,0,0,0));
    tbl.push_back(mk(0,0, 0, 0, 0,0,1, 23,59,58, 1,0,0,0));
    tbl.push_back(mk(0,1, 0, 5, 0,0,0,  0, 5, 0, 0,0,0,0)); // 0:05:00
    tbl.push_back(mk(0,0, 0, 0, 0,1,0,  0, 5, 0, 1,0,0,0)); // running

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i]);

    // Reset between edges while running: outputs clear without a clock edge.
    Tick = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    check_outputs("rst_async", z);
    @(posedge CLK);
    #1;
    check_outputs("rst_held", z);
    @(negedge CLK);
    RST_N = 1'b1;
    step("post_rst", mk(1,0, 0, 0, 0,0,0,  0, 0, 0, 0,0,0,0)); // idle, no done
    step("post_ld",  mk(0,1, 0, 0, 1,0,0,  0, 0, 1, 0,0,0,0));
    step("post_st",  mk(0,0, 0, 0, 0,1,0,  0, 0, 1, 1,0,0,0));
    step("post_exp", mk(1,0, 0, 0, 0,0,0,  0, 0, 0, 0,1,1,0));
    step("post_hld", mk(1,0, 0, 0, 0,1,0,  0, 0, 0, 0,0,1,0));

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
